target_rst_ctrl: RTL and testbench
==================================

TARGET_RST_CTRL -- requirements
Module: target_rst_ctrl

Interface
REQ-001 Parameter N_CH, default 4, number of target boards (1..16).
REQ-002 Parameter PULSE_CYCLES, default 16, reset-low duration in clk cycles (>=1).
REQ-003 Parameter HOLDOFF_CYCLES, default 1024, post-pulse command lockout in clk cycles (>=0).
REQ-004 Parameter CMD_RST, default 8'h41 ('A'): pulse the selected channel.
REQ-005 Parameter CMD_SEL, default 8'h53 ('S'): the next byte is the channel index.
REQ-006 Parameter CMD_ALL, default 8'h52 ('R'): pulse all channels.
REQ-007 Port: clk, input, 1, sole clock.
REQ-008 Port: rst_n, input, 1, reset, synchronous, active-low.
REQ-009 Port: rx_data, input, 8, byte from host UART receiver.
REQ-010 Port: rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-011 Port: host_rx, input, 1, raw host serial line.
REQ-012 Port: host_tx, output, 1, serial line back to host.
REQ-013 Port: target_tx, output, N_CH, serial lines to targets.
REQ-014 Port: target_rx, input, N_CH, serial lines from targets.
REQ-015 Port: target_rst, output, N_CH, active-low target resets.
REQ-016 Port: sel, output, clog2(N_CH) (min 1), currently selected channel.
REQ-017 Port: busy, output, 1, high in PULSE or HOLDOFF.
REQ-018 Port: sel_err, output, 1, one-cycle strobe on an out-of-range index.
REQ-019 Port: ack_data, output, 8, acknowledge byte.
REQ-020 Port: ack_valid, output, 1, acknowledge byte valid.
REQ-021 Port: ack_ready, input, 1, consumer accepts the ack byte.

Function
REQ-022 Passthrough (combinational):
- target_tx[sel] SHALL equal host_rx.
- Every other target_tx bit SHALL be 1 (idle).
- host_tx SHALL equal target_rx[sel].
REQ-023 FSM states SHALL be IDLE, SEL_WAIT, PULSE, HOLDOFF, ACK.
REQ-024 IDLE transitions on rx_valid:
- CMD_SEL -> SEL_WAIT.
- CMD_RST -> PULSE, with mask = one-hot(sel).
- CMD_ALL -> PULSE, with mask = all ones.
- Any other byte is ignored.
REQ-025 SEL_WAIT, next rx_valid:
- If rx_data < N_CH, sel SHALL load rx_data[clog2(N_CH)-1:0] and the FSM returns to IDLE.
- Otherwise sel SHALL hold, sel_err SHALL pulse for 1 cycle, and the FSM returns to IDLE.
REQ-026 Pulse timing: for a command accepted at edge t, target_rst bits in mask SHALL be 0 from edge t+1 for exactly PULSE_CYCLES cycles; the other bits SHALL stay 1.
REQ-027 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles; with HOLDOFF_CYCLES=0 the FSM goes PULSE -> ACK/IDLE directly.
REQ-028 Every rx_valid byte arriving in PULSE, HOLDOFF or ACK SHALL be dropped without side effects, including selection bytes.
REQ-029 sel SHALL NOT change during PULSE, HOLDOFF or ACK; passthrough follows sel continuously.
REQ-030 The cycle counter SHALL be clog2(max(PULSE_CYCLES,HOLDOFF_CYCLES)+1) bits, count down to 1, and never wrap.
REQ-031 busy SHALL be 1 exactly while the FSM is in PULSE or HOLDOFF.

Reset
REQ-032 On rst_n=0 at a clk edge, the block SHALL enter IDLE and set:
- sel = 0, counter = 0, mask = 0, busy = 0, sel_err = 0, ack_valid = 0.
- target_rst = all ones (released).
REQ-033 Reset asserted mid-PULSE SHALL release all target_rst bits at the same edge; no residual pulse follows.

Configuration
REQ-034 Macro TARGET_RST_CTRL_ACK_EN.
- Defined: after HOLDOFF the FSM SHALL enter ACK and drive ack_valid=1 with ack_data=8'h06 (8'h15 if the pulse was CMD_ALL), holding both until the cycle ack_valid&ack_ready, then return to IDLE.
- Undefined: the ACK state is absent, ack_valid is constant 0, ack_data is constant 0, and ack_ready is ignored.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and default command byte constants (CMD_RST/SEL/ALL, ACK 8'h06/8'h15).
REQ-036 The pulse/holdoff down-counter SHALL be one sub-module, pulse_timer (load, count, done).

Verification
REQ-037 N_CH=4, sel=0: rx 'A' at edge t -> target_rst=4'b1110 from t+1 to t+16, busy high through holdoff.
REQ-038 rx 'S' then 8'h02 -> sel=2, host_rx toggles appear only on target_tx[2], host_tx follows target_rx[2].
REQ-039 rx 'S' then 8'h07 -> sel_err one-cycle pulse, sel unchanged at 0.
REQ-040 rx 'R' then 'A' at pulse cycle 3 -> target_rst=4'b0000 for 16 cycles; the second command is dropped with no second pulse.
REQ-041 rst_n low at pulse cycle 5 -> target_rst=4'b1111 on the next edge, FSM in IDLE.
REQ-042 With ACK_EN, ack_ready held low 10 cycles after holdoff -> ack_valid and ack_data=8'h06 stable; the byte is accepted on the ready cycle, followed by IDLE.

Source files
------------

// File: rtl/target_rst_ctrl_pkg.sv
// Shared types and constants for the target reset controller:
// FSM state encoding, default host command bytes, ack codes and width helpers.
package target_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL_WAIT = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

  localparam logic [7:0] CMD_RST_DEF = 8'h41;
  localparam logic [7:0] CMD_SEL_DEF = 8'h53;
  localparam logic [7:0] CMD_ALL_DEF = 8'h52;
  localparam logic [7:0] ACK_OK      = 8'h06;
  localparam logic [7:0] ACK_ALL     = 8'h15;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold the larger of the two loaded durations.
  function automatic int unsigned cnt_width(input int unsigned p, input int unsigned h);
    int unsigned m;
    m = (p > h) ? p : h;
    return (m + 1 > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/target_rst_ctrl_timer.sv
// pulse_timer: loadable down-counter shared by the PULSE and HOLDOFF phases.
// Counts down to 1 and parks there; done is high while the count is 1.
module pulse_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt > W'(1))) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/target_rst_ctrl.sv
// Host-commanded reset pulser and UART passthrough for N_CH target boards.
// Optional acknowledge handshake enabled by defining TARGET_RST_CTRL_ACK_EN.
module target_rst_ctrl
  import target_rst_ctrl_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter logic [7:0]  CMD_RST        = CMD_RST_DEF,
  parameter logic [7:0]  CMD_SEL        = CMD_SEL_DEF,
  parameter logic [7:0]  CMD_ALL        = CMD_ALL_DEF,
  localparam int unsigned SEL_W         = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             host_rx,
  output logic             host_tx,
  output logic [N_CH-1:0]  target_tx,
  input  logic [N_CH-1:0]  target_rx,
  output logic [N_CH-1:0]  target_rst,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             sel_err,
  output logic [7:0]       ack_data,
  output logic             ack_valid,
  input  logic             ack_ready
);

  localparam int unsigned CNT_W = cnt_width(PULSE_CYCLES, HOLDOFF_CYCLES);

`ifdef TARGET_RST_CTRL_ACK_EN
  localparam state_t ST_AFTER_PULSE = ST_ACK;
`else
  localparam state_t ST_AFTER_PULSE = ST_IDLE;
`endif

  state_t           r_state, w_state_next;
  logic [N_CH-1:0]  r_mask, w_mask_next;
  logic [N_CH-1:0]  r_target_rst;
  logic [N_CH-1:0]  w_sel_onehot;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic             r_sel_err, w_sel_err_next;
  logic             r_ack_all, w_ack_all_next;
  logic             w_load, w_count, w_done;
  logic [CNT_W-1:0] w_load_val;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_onehot
      assign w_sel_onehot[gi] = (r_sel == SEL_W'(gi));
    end
  endgenerate

  pulse_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_count    (w_count),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_next   = r_state;
    w_mask_next    = r_mask;
    w_sel_next     = r_sel;
    w_sel_err_next = 1'b0;
    w_ack_all_next = r_ack_all;
    w_load         = 1'b0;
    w_load_val     = CNT_W'(PULSE_CYCLES);
    w_count        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_SEL) begin
            w_state_next = ST_SEL_WAIT;
          end else if (rx_data == CMD_RST) begin
            w_state_next   = ST_PULSE;
            w_mask_next    = w_sel_onehot;
            w_ack_all_next = 1'b0;
            w_load         = 1'b1;
          end else if (rx_data == CMD_ALL) begin
            w_state_next   = ST_PULSE;
            w_mask_next    = '1;
            w_ack_all_next = 1'b1;
            w_load         = 1'b1;
          end
        end
      end
      ST_SEL_WAIT: begin
        if (rx_valid) begin
          w_state_next = ST_IDLE;
          if (32'(rx_data) < N_CH) begin
            w_sel_next = rx_data[SEL_W-1:0];
          end else begin
            w_sel_err_next = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        w_count = 1'b1;
        if (w_done) begin
          w_mask_next = '0;
          if (HOLDOFF_CYCLES > 0) begin
            w_state_next = ST_HOLDOFF;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(HOLDOFF_CYCLES);
          end else begin
            w_state_next = ST_AFTER_PULSE;
          end
        end
      end
      ST_HOLDOFF: begin
        w_count = 1'b1;
        if (w_done) begin
          w_state_next = ST_AFTER_PULSE;
        end
      end
`ifdef TARGET_RST_CTRL_ACK_EN
      ST_ACK: begin
        if (ack_ready) begin
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Reset outputs are registered from the next state so they switch on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_sel        <= '0;
      r_sel_err    <= 1'b0;
      r_ack_all    <= 1'b0;
      r_target_rst <= '1;
    end else begin
      r_state      <= w_state_next;
      r_mask       <= w_mask_next;
      r_sel        <= w_sel_next;
      r_sel_err    <= w_sel_err_next;
      r_ack_all    <= w_ack_all_next;
      r_target_rst <= (w_state_next == ST_PULSE) ? ~w_mask_next : '1;
    end
  end

  always_comb begin
    target_tx        = '1;
    target_tx[r_sel] = host_rx;
    host_tx          = target_rx[r_sel];
  end

  assign target_rst = r_target_rst;
  assign sel        = r_sel;
  assign sel_err    = r_sel_err;
  assign busy       = (r_state == ST_PULSE) || (r_state == ST_HOLDOFF);

`ifdef TARGET_RST_CTRL_ACK_EN
  assign ack_valid = (r_state == ST_ACK);
  assign ack_data  = r_ack_all ? ACK_ALL : ACK_OK;
`else
  logic w_unused_ack;
  assign w_unused_ack = ack_ready | r_ack_all;
  assign ack_valid    = 1'b0;
  assign ack_data     = 8'h00;
`endif

endmodule

// File: tb/tb_target_rst_ctrl.sv
// Self-checking bench for target_rst_ctrl with default parameters.
// Acknowledge checks follow TARGET_RST_CTRL_ACK_EN when it is defined.
module tb_target_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       host_rx;
  logic       host_tx;
  logic [3:0] target_tx;
  logic [3:0] target_rx;
  logic [3:0] target_rst;
  logic [1:0] sel;
  logic       busy;
  logic       sel_err;
  logic [7:0] ack_data;
  logic       ack_valid;
  logic       ack_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  target_rst_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .host_rx    (host_rx),
    .host_tx    (host_tx),
    .target_tx  (target_tx),
    .target_rx  (target_rx),
    .target_rst (target_rst),
    .sel        (sel),
    .busy       (busy),
    .sel_err    (sel_err),
    .ack_data   (ack_data),
    .ack_valid  (ack_valid),
    .ack_ready  (ack_ready)
  );

  typedef struct {
    logic [7:0] idx;
    logic       hrx;
    logic [3:0] trx;
    logic [1:0] e_sel;
    logic       e_err;
    logic [3:0] e_ttx;
    logic       e_htx;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Presents one byte for a single clock edge; returns on the negedge after that edge.
  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h07, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b1110, 1'b1};
    vecs[1] = '{8'h41, 1'b1, 4'b0000, 2'd0, 1'b1, 4'b1111, 1'b0};
    vecs[2] = '{8'h02, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b1011, 1'b1};
    vecs[3] = '{8'h02, 1'b1, 4'b1011, 2'd2, 1'b0, 4'b1111, 1'b0};
    vecs[4] = '{8'h04, 1'b0, 4'b1000, 2'd2, 1'b1, 4'b1011, 1'b0};
    vecs[5] = '{8'h03, 1'b0, 4'b1000, 2'd3, 1'b0, 4'b0111, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 4'b0111, 2'd3, 1'b1, 4'b1111, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 4'b1110, 2'd0, 1'b0, 4'b1110, 1'b0};
    vecs[8] = '{8'h01, 1'b0, 4'b0010, 2'd1, 1'b0, 4'b1101, 1'b1};

    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    host_rx   = 1'b0;
    target_rx = 4'b0001;
    ack_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset target_rst", 32'(target_rst), 32'hF);
    check("reset busy", 32'(busy), 0);
    check("reset sel", 32'(sel), 0);
    check("reset sel_err", 32'(sel_err), 0);
    check("reset ack_valid", 32'(ack_valid), 0);
    check("reset target_tx", 32'(target_tx), 32'hE);
    check("reset host_tx", 32'(host_tx), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Unknown byte in IDLE is ignored.
    rx_byte(8'h00);
    check("unknown byte busy", 32'(busy), 0);
    check("unknown byte target_rst", 32'(target_rst), 32'hF);

    // Single-channel pulse on channel 0 followed by holdoff.
    begin
      int cnt;
      int h;
      ack_ready = 1'b0;
      rx_byte(8'h41);
      cnt = 0;
      while (cnt < 40 && target_rst == 4'b1110 && busy) begin
        cnt++;
        @(negedge clk);
      end
      check("A pulse length", 32'(cnt), 16);
      h = 0;
      while (h < 2000 && busy && target_rst == 4'b1111) begin
        h++;
        @(negedge clk);
      end
      check("A holdoff length", 32'(h), 1024);
      check("A busy after holdoff", 32'(busy), 0);
`ifdef TARGET_RST_CTRL_ACK_EN
      begin
        int stable;
        check("A ack_valid", 32'(ack_valid), 1);
        check("A ack_data", 32'(ack_data), 32'h06);
        stable = 0;
        repeat (10) begin
          @(negedge clk);
          if (ack_valid === 1'b1 && ack_data === 8'h06) stable++;
        end
        check("A ack stable while not ready", 32'(stable), 10);
        ack_ready = 1'b1;
        @(negedge clk);
        check("A ack_valid after accept", 32'(ack_valid), 0);
        check("A busy after accept", 32'(busy), 0);
      end
`else
      check("A ack_valid idle", 32'(ack_valid), 0);
      check("A ack_data idle", 32'(ack_data), 0);
      ack_ready = 1'b1;
`endif
    end

    // Selection and passthrough vectors.
    for (int i = 0; i < 9; i++) begin
      rx_byte(8'h53);
      rx_byte(vecs[i].idx);
      check($sformatf("v%0d sel_err strobe", i), 32'(sel_err), 32'(vecs[i].e_err));
      @(negedge clk);
      check($sformatf("v%0d sel_err clears", i), 32'(sel_err), 0);
      host_rx   = vecs[i].hrx;
      target_rx = vecs[i].trx;
      #1;
      check($sformatf("v%0d sel", i), 32'(sel), 32'(vecs[i].e_sel));
      check($sformatf("v%0d target_tx", i), 32'(target_tx), 32'(vecs[i].e_ttx));
      check($sformatf("v%0d host_tx", i), 32'(host_tx), 32'(vecs[i].e_htx));
      check($sformatf("v%0d busy", i), 32'(busy), 0);
    end
    host_rx = 1'b0;

    // Pulse-all with bytes arriving during pulse and holdoff that must be dropped.
    begin
      int cnt;
      int cyc;
      int h;
      int bad;
      int q;
      rx_byte(8'h52);
      cnt = 0;
      cyc = 0;
      while (cyc < 40 && target_rst == 4'b0000) begin
        cnt++;
        cyc++;
        if (cyc == 3) begin
          rx_data  = 8'h41;
          rx_valid = 1'b1;
        end else begin
          rx_valid = 1'b0;
        end
        @(negedge clk);
      end
      rx_valid = 1'b0;
      check("R pulse length", 32'(cnt), 16);
      h = 0;
      bad = 0;
      while (h < 2000 && busy) begin
        if (target_rst != 4'b1111) bad++;
        h++;
        if (h == 10) begin
          rx_data  = 8'h53;
          rx_valid = 1'b1;
        end else if (h == 12) begin
          rx_data  = 8'h00;
          rx_valid = 1'b1;
        end else begin
          rx_valid = 1'b0;
        end
        @(negedge clk);
      end
      rx_valid = 1'b0;
      check("R holdoff length", 32'(h), 1024);
      check("R no second pulse in holdoff", 32'(bad), 0);
      check("R sel kept through busy", 32'(sel), 1);
`ifdef TARGET_RST_CTRL_ACK_EN
      check("R ack_valid", 32'(ack_valid), 1);
      check("R ack_data", 32'(ack_data), 32'h15);
`else
      check("R ack_valid idle", 32'(ack_valid), 0);
`endif
      q = 0;
      repeat (20) begin
        @(negedge clk);
        if (target_rst != 4'b1111 || busy) q++;
      end
      check("R quiet after holdoff", 32'(q), 0);
      check("R sel after idle", 32'(sel), 1);
    end

    // Reset asserted at pulse cycle 5 releases immediately.
    begin
      int q;
      rx_byte(8'h41);
      check("mid-reset pulse on ch1", 32'(target_rst), 32'hD);
      repeat (4) @(negedge clk);
      check("mid-reset still pulsing", 32'(target_rst), 32'hD);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-reset target_rst released", 32'(target_rst), 32'hF);
      check("mid-reset busy", 32'(busy), 0);
      check("mid-reset sel", 32'(sel), 0);
      rst_n = 1'b1;
      q = 0;
      repeat (30) begin
        @(negedge clk);
        if (target_rst != 4'b1111 || busy) q++;
      end
      check("mid-reset no residual pulse", 32'(q), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
